uart_tx_fifo: RTL and testbench

//  Byte-wide UART transmitter with an input FIFO. It sits directly downstream of uart_debugger:
//  the debugger pushes formatted sample bytes through a valid/ready handshake, and this block

---
 rtl/uart_tx_fifo.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a byte FIFO.
// An upstream source (uart_debugger) pushes bytes through a valid/ready
// handshake. The FIFO absorbs bursts while the serializer drains it at a
// fixed baud rate.
// Ports:
//   clk_25mhz  system clock
//   rst_n_in   asynchronous active-low reset
//   data_in    byte to transmit
//   valid_in   data_in is valid
//   ready_out  FIFO can accept a byte this cycle
//   level_out  bytes held in the FIFO (excludes the byte being shifted)
//   busy_out   a frame is on the line or the FIFO is non-empty
//   uart_tx    serial line, idles high, driven from a flop
module uart_tx_fifo #(
  parameter int unsigned CLK_HZ     = 25_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk_25mhz,
  input  logic                          rst_n_in,
  input  logic [7:0]                    data_in,
  input  logic                          valid_in,
  output logic                          ready_out,
  output logic [$clog2(FIFO_DEPTH):0]   level_out,
  output logic                          busy_out,
  output logic                          uart_tx
);

  localparam int unsigned BAUD_DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam int unsigned PW       = AW + 1;
  localparam int unsigned CW       = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [PW-1:0] FULL_LVL  = PW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // FIFO storage and pointers; one extra pointer bit distinguishes full from empty
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          empty;

  state_t        state;
  state_t        state_d;
  logic [CW-1:0] baud_cnt;
  logic [CW-1:0] baud_d;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_d;
  logic [7:0]    shift;
  logic [7:0]    shift_d;
  logic          tx_d;
  logic          baud_end;

  assign level_out = wr_ptr - rd_ptr;
  assign empty     = (level_out == '0);
  // Full blocks the push even when a pop happens in the same cycle
  assign ready_out = (level_out != FULL_LVL);
  assign push      = valid_in && ready_out;
  assign busy_out  = (state != IDLE) || !empty;
  assign baud_end  = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk_25mhz) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk_25mhz or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_25mhz or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      uart_tx  <= 1'b1;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_d;
      bit_idx  <= bit_d;
      shift    <= shift_d;
      uart_tx  <= tx_d;
    end
  end

  always_comb begin
    state_d = state;
    baud_d  = baud_cnt;
    bit_d   = bit_idx;
    shift_d = shift;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr[AW-1:0]];
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift[7:1]};
          bit_d   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          baud_d = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr[AW-1:0]];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is registered from the next state so uart_tx changes on the
    // same edge as the state it belongs to
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo at CLK_HZ=1000, BAUD=100
// (10 clocks per bit). A line monitor decodes frames and checks bit timing;
// decoded bytes are compared against the bytes the bench pushed.
module tb_uart_tx_fifo;

  logic       clk_25mhz = 1'b0;
  logic       rst_n_in;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic [4:0] level_out;
  logic       busy_out;
  logic       uart_tx;

  uart_tx_fifo #(
    .CLK_HZ     (1000),
    .BAUD       (100),
    .FIFO_DEPTH (16)
  ) dut (
    .clk_25mhz (clk_25mhz),
    .rst_n_in  (rst_n_in),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .level_out (level_out),
    .busy_out  (busy_out),
    .uart_tx   (uart_tx)
  );

  always #5 clk_25mhz = ~clk_25mhz;

  int unsigned cyc = 0;
  always @(posedge clk_25mhz) cyc <= cyc + 1;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  logic [7:0]  exp_q[$];
  logic [7:0]  rx_q[$];
  int unsigned start_q[$];

  bit          mon_en = 1'b1;
  bit          lvl_en = 1'b0;
  bit          mon_busy = 1'b0;
  bit          pend = 1'b0;
  int unsigned mon_pos = 0;
  int unsigned pops = 0;
  int unsigned accepted = 0;
  logic        cell_first;
  logic        cell_bad;
  logic [7:0]  rx_shift;

  // Line monitor and level model, sampled on the falling edge
  initial begin
    forever begin
      @(negedge clk_25mhz);
      if (!mon_en) begin
        mon_busy = 1'b0;
        pend     = 1'b0;
        accepted = 0;
        pops     = 0;
      end else begin
        if (pend) accepted++;
        pend = valid_in && ready_out;
        if (!mon_busy) begin
          if (uart_tx === 1'b0) begin
            mon_busy = 1'b1;
            mon_pos  = 0;
            cell_bad = 1'b0;
            pops++;
            start_q.push_back(cyc);
          end
        end else begin
          mon_pos++;
        end
        if (mon_busy) begin
          if (mon_pos % 10 == 0) cell_first = uart_tx;
          else if (uart_tx !== cell_first) cell_bad = 1'b1;
          if (mon_pos % 10 == 9) begin
            if (mon_pos / 10 == 0) begin
              check("start_bit", cell_first, 0);
            end else if (mon_pos / 10 <= 8) begin
              rx_shift = {cell_first, rx_shift[7:1]};
            end else begin
              check("stop_bit", cell_first, 1);
              check("bit_timing", cell_bad, 0);
              rx_q.push_back(rx_shift);
              mon_busy = 1'b0;
            end
          end
        end
        if (lvl_en) check("level_model", level_out, accepted - pops);
      end
    end
  end

  // Starts at posedge+1; returns at posedge+1 after the accepting edge
  task automatic push(input logic [7:0] d, output int unsigned acc_cyc, output int unsigned waits);
    waits    = 0;
    acc_cyc  = 0;
    valid_in = 1'b1;
    data_in  = d;
    @(negedge clk_25mhz);
    while (!ready_out && waits < 5000) begin
      @(negedge clk_25mhz);
      waits++;
    end
    if (!ready_out) begin
      check("push_timeout", ready_out, 1);
      valid_in = 1'b0;
    end else begin
      @(posedge clk_25mhz);
      #1;
      valid_in = 1'b0;
      acc_cyc  = cyc;
      exp_q.push_back(d);
    end
  endtask

  task automatic wait_idle(input int unsigned limit);
    int unsigned n = 0;
    @(negedge clk_25mhz);
    while (busy_out && n < limit) begin
      @(negedge clk_25mhz);
      n++;
    end
    check("drain_timeout", busy_out, 0);
    repeat (2) @(negedge clk_25mhz);
    @(posedge clk_25mhz);
    #1;
  endtask

  task automatic compare_rx();
    check("rx_count", rx_q.size(), exp_q.size());
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      check("rx_data", rx_q.pop_front(), exp_q.pop_front());
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic check_gap(input string tag, input int unsigned idx, input int unsigned gap);
    if (start_q.size() > idx + 1) check(tag, start_q[idx+1] - start_q[idx], gap);
    else check({tag, "_missing"}, start_q.size(), idx + 2);
  endtask

  int unsigned c, c0, w, sidx;
  logic        e;
  logic [7:0]  b;

  initial begin
    rst_n_in = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    repeat (3) @(posedge clk_25mhz);
    #1;
    check("rst_tx", uart_tx, 1);
    check("rst_ready", ready_out, 1);
    check("rst_level", level_out, 0);
    check("rst_busy", busy_out, 0);
    rst_n_in = 1'b1;
    lvl_en   = 1'b1;
    @(posedge clk_25mhz);
    #1;

    // Single byte waveform
    b    = 8'hA5;
    sidx = start_q.size();
    push(b, c, w);
    for (int unsigned j = 0; j <= 101; j++) begin
      @(negedge clk_25mhz);
      if (j == 0) e = 1'b1;
      else if (j <= 10) e = 1'b0;
      else if (j <= 90) e = b[(j-11)/10];
      else e = 1'b1;
      check("t2_tx", uart_tx, e);
      if (j == 0) begin
        check("t2_level0", level_out, 1);
        check("t2_busy0", busy_out, 1);
      end
      if (j == 1) check("t2_level1", level_out, 0);
      if (j == 100) check("t2_busy100", busy_out, 1);
      if (j == 101) check("t2_busy101", busy_out, 0);
    end
    check("t2_starts", start_q.size(), sidx + 1);
    if (start_q.size() > sidx) check("t2_start_cyc", start_q[sidx], c + 1);
    @(posedge clk_25mhz);
    #1;
    compare_rx();

    // Burst of three on consecutive cycles
    sidx = start_q.size();
    push(8'h00, c, w);
    check("t3_level_a", level_out, 1);
    push(8'hFF, c, w);
    check("t3_level_b", level_out, 1);
    push(8'h55, c, w);
    check("t3_level_c", level_out, 2);
    wait_idle(1000);
    check_gap("t3_gap", sidx, 100);
    check_gap("t3_gap", sidx + 1, 100);
    compare_rx();

    // Fill 17 bytes with valid held, then push one more into a full FIFO
    sidx = start_q.size();
    for (int unsigned i = 0; i < 17; i++) begin
      push(8'(8'h10 + i), c, w);
      if (i == 0) c0 = c;
      check("t4_wait", w, 0);
    end
    check("t4_ready_full", ready_out, 0);
    check("t4_level_full", level_out, 16);
    push(8'hEE, c, w);
    check("t5_accept_cyc", c, c0 + 102);
    check("t5_level", level_out, 16);
    check("t5_ready", ready_out, 0);
    wait_idle(3000);
    for (int unsigned i = 0; i < 17; i++) check_gap("t4_gap", sidx + i, 100);
    compare_rx();

    // Push landing on the stop-end edge of the last byte: one idle clock
    sidx = start_q.size();
    push(8'h3C, c0, w);
    while (cyc < c0 + 100) begin
      @(posedge clk_25mhz);
      #1;
    end
    push(8'hC3, c, w);
    check("t7_accept_cyc", c, c0 + 101);
    wait_idle(1000);
    check_gap("t7_gap", sidx, 101);
    compare_rx();

    // Random data with random gaps
    for (int unsigned i = 0; i < 500; i++) begin
      w = ($urandom_range(0, 19) == 0) ? 150 : $urandom_range(0, 3);
      repeat (w) begin
        @(posedge clk_25mhz);
        #1;
      end
      push(8'($urandom), c, w);
    end
    wait_idle(5000);
    compare_rx();

    // Reset in the middle of a frame
    push(8'h00, c, w);
    push(8'h81, c, w);
    repeat (40) @(negedge clk_25mhz);
    check("t1_pre_tx", uart_tx, 0);
    check("t1_pre_level", level_out, 1);
    mon_en = 1'b0;
    lvl_en = 1'b0;
    #2;
    rst_n_in = 1'b0;
    #1;
    check("t1_async_tx", uart_tx, 1);
    check("t1_async_ready", ready_out, 1);
    check("t1_async_level", level_out, 0);
    check("t1_async_busy", busy_out, 0);
    repeat (3) @(posedge clk_25mhz);
    #1;
    check("t1_hold_tx", uart_tx, 1);
    rst_n_in = 1'b1;
    repeat (3) @(posedge clk_25mhz);
    #1;
    check("t1_post_tx", uart_tx, 1);
    check("t1_post_busy", busy_out, 0);
    check("t1_post_level", level_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
